sram_fifo_ctrl: RTL and testbench

SRAM_FIFO_CTRL -- requirements
Module: sram_fifo_ctrl

---
 rtl/sram_fifo_ctrl.sv | 90 +++++++++
 tb/tb_sram_fifo_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: FIFO controller over a dual-port SRAM with a 2-entry output buffer
module sram_fifo_ctrl #(
    parameter int DW = 32,
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic [AW:0]   count,
    output logic          sram_ena,
    output logic          sram_wea,
    output logic [AW-1:0] sram_addra,
    output logic [DW-1:0] sram_dina,
    output logic          sram_enb,
    output logic          sram_web,
    output logic [AW-1:0] sram_addrb,
    output logic [DW-1:0] sram_dinb,
    input  logic [DW-1:0] sram_doutb
);
    localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   mem_cnt_q, mem_cnt_d;
    logic          rd_pend_q, rd_pend_d;
    logic [1:0]    obuf_cnt_q, obuf_cnt_d;
    logic          head_q, head_d;
    logic [DW-1:0] obuf_q [2];
    logic          push, pop, issue;
    logic [1:0]    occ;

    // rst_n gating keeps the write port quiet while reset is held
    assign in_ready   = rst_n && !flush && (mem_cnt_q != FULL);
    assign push       = in_valid && in_ready;
    assign out_valid  = obuf_cnt_q != 2'd0;
    assign pop        = out_valid && out_ready;
    // buffer slots already claimed after this cycle's pop; a read is issued only into a free slot
    assign occ        = obuf_cnt_q + {1'b0, rd_pend_q} - {1'b0, pop};
    assign issue      = (mem_cnt_q != '0) && !flush && (occ < 2'd2);
    assign out_data   = obuf_q[head_q];
    assign count      = mem_cnt_q + (AW+1)'(rd_pend_q) + (AW+1)'(obuf_cnt_q);
    assign sram_ena   = push;
    assign sram_wea   = push;
    assign sram_addra = wr_ptr_q;
    assign sram_dina  = in_data;
    assign sram_enb   = issue;
    assign sram_web   = 1'b0;
    assign sram_addrb = rd_ptr_q;
    assign sram_dinb  = '0;

    // next-state for pointers and occupancy; flush wins over everything
    always_comb begin
        wr_ptr_d   = flush ? '0 : wr_ptr_q + AW'(push);
        rd_ptr_d   = flush ? '0 : rd_ptr_q + AW'(issue);
        mem_cnt_d  = flush ? '0 : mem_cnt_q + (AW+1)'(push) - (AW+1)'(issue);
        rd_pend_d  = !flush && issue;
        obuf_cnt_d = flush ? '0 : obuf_cnt_q + {1'b0, rd_pend_q} - {1'b0, pop};
        head_d     = !flush && (head_q ^ pop);
    end

    // control state with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            mem_cnt_q  <= '0;
            rd_pend_q  <= 1'b0;
            obuf_cnt_q <= '0;
            head_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_cnt_q  <= mem_cnt_d;
            rd_pend_q  <= rd_pend_d;
            obuf_cnt_q <= obuf_cnt_d;
            head_q     <= head_d;
        end
    end

    // capture returning SRAM data into the slot just behind the buffered entries
    always_ff @(posedge clk) begin
        if (rd_pend_q && !flush)
            obuf_q[head_q ^ obuf_cnt_q[0]] <= sram_doutb;
    end
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb_sram_fifo_ctrl: vector table, queue reference model and corner sequences for sram_fifo_ctrl
module tb_sram_fifo_ctrl;
    localparam int DW = 32;
    localparam int AW = 9;

    logic          clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
    logic          in_valid = 1'b0, out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, out_valid;
    logic [DW-1:0] out_data;
    logic [AW:0]   count;
    logic          sram_ena, sram_wea, sram_enb, sram_web;
    logic [AW-1:0] sram_addra, sram_addrb;
    logic [DW-1:0] sram_dina, sram_dinb, sram_doutb;
    logic [DW-1:0] mem [512];

    int total = 0, bad = 0;
    logic [DW-1:0] q[$];
    bit acc;

    typedef struct {
        bit iv; logic [31:0] d; bit ordy; bit fl;
        bit ov; logic [31:0] od; int cnt; bit ir;
    } vec_t;
    vec_t tbl[12];

    sram_fifo_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .count(count),
        .sram_ena(sram_ena), .sram_wea(sram_wea), .sram_addra(sram_addra), .sram_dina(sram_dina),
        .sram_enb(sram_enb), .sram_web(sram_web), .sram_addrb(sram_addrb), .sram_dinb(sram_dinb),
        .sram_doutb(sram_doutb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sram_ena && sram_wea) mem[sram_addra] <= sram_dina;
        if (sram_enb && !sram_web) sram_doutb <= mem[sram_addrb];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // one clock of stimulus, checked against the queue model
    task automatic cyc(input bit iv, input logic [DW-1:0] d, input bit ordy, input bit fl);
        bit pu, po, stall;
        logic [DW-1:0] pd;
        @(negedge clk);
        in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
        #1;
        if (fl) chk("in_ready_flush", in_ready, 0);
        else if (q.size() < 512) chk("in_ready_free", in_ready, 1);
        if (out_valid) begin
            if (q.size() == 0) chk("spurious_valid", out_valid, 0);
            else chk("out_data", out_data, q[0]);
        end
        pu = iv && in_ready;
        po = out_valid && ordy;
        stall = out_valid && !ordy && !fl;
        pd = out_data;
        acc = pu;
        @(posedge clk);
        #1;
        if (fl) q.delete();
        else begin
            if (po && q.size() > 0) void'(q.pop_front());
            if (pu) q.push_back(d);
        end
        chk("count", count, q.size());
        if (stall) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, pd);
        end
    endtask

    initial begin
        #2_000_000;
        bad++;
        $display("FAIL watchdog: got timeout want finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int nxt;
        tbl[0]  = '{1, 32'hA5A50001, 1, 0, 0, 32'h0,        1, 1};
        tbl[1]  = '{0, 32'h0,        1, 0, 0, 32'h0,        1, 1};
        tbl[2]  = '{0, 32'h0,        0, 0, 1, 32'hA5A50001, 1, 1};
        tbl[3]  = '{0, 32'h0,        1, 0, 0, 32'h0,        0, 1};
        tbl[4]  = '{1, 32'h11,       0, 0, 0, 32'h0,        1, 1};
        tbl[5]  = '{1, 32'h22,       0, 0, 0, 32'h0,        2, 1};
        tbl[6]  = '{0, 32'h0,        0, 0, 1, 32'h11,       2, 1};
        tbl[7]  = '{0, 32'h0,        0, 1, 0, 32'h0,        0, 0};
        tbl[8]  = '{1, 32'h33,       1, 0, 0, 32'h0,        1, 1};
        tbl[9]  = '{0, 32'h0,        1, 0, 0, 32'h0,        1, 1};
        tbl[10] = '{0, 32'h0,        0, 0, 1, 32'h33,       1, 1};
        tbl[11] = '{0, 32'h0,        1, 0, 0, 32'h0,        0, 1};

        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_sram_ena", sram_ena, 0);
        chk("rst_sram_enb", sram_enb, 0);
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);

        foreach (tbl[i]) begin
            @(negedge clk);
            in_valid = tbl[i].iv; in_data = tbl[i].d; out_ready = tbl[i].ordy; flush = tbl[i].fl;
            #1;
            chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].ir);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].ov);
            if (tbl[i].ov) chk($sformatf("tbl%0d_out_data", i), out_data, tbl[i].od);
            chk($sformatf("tbl%0d_count", i), count, tbl[i].cnt);
        end

        nxt = 0;
        for (int i = 0; i < 530 && nxt < 514; i++) begin
            cyc(1, DW'(nxt), 0, 0);
            if (acc) nxt++;
        end
        chk("fill_count", count, 514);
        chk("fill_in_ready", in_ready, 0);
        repeat (520) cyc(0, '0, 1, 0);
        chk("drain_count", count, 0);

        for (int i = 0; i < 2010; i++) begin
            cyc(1, 32'h10000 + DW'(i), 1, 0);
            if (i >= 2) chk("no_bubble", out_valid, 1);
        end
        repeat (5) cyc(0, '0, 1, 0);

        repeat (3000) cyc(($urandom % 4) != 0, $urandom, ($urandom % 10) < 3, ($urandom % 500) == 0);

        cyc(0, '0, 1, 1);
        for (int i = 0; i < 100; i++) cyc(1, 32'hF000 + DW'(i), 0, 0);
        cyc(0, '0, 1, 0);
        cyc(0, '0, 0, 1);
        chk("flush_out_valid", out_valid, 0);
        cyc(1, 32'hBEEF, 0, 0);
        cyc(0, '0, 0, 0);
        cyc(0, '0, 0, 0);
        chk("flush_new_valid", out_valid, 1);
        chk("flush_new_data", out_data, 32'hBEEF);
        cyc(0, '0, 1, 0);

        repeat (20) cyc(1, $urandom, 1, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        chk("async_out_valid", out_valid, 0);
        chk("async_count", count, 0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 32'h1234, 0, 0);
        cyc(0, '0, 0, 0);
        cyc(0, '0, 0, 0);
        chk("async_pop_valid", out_valid, 1);
        chk("async_pop_data", out_data, 32'h1234);
        cyc(0, '0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
